// File: rtl/bike_pkg.sv
// Shared encodings and constants for the bicycle computer blocks.
package bike_pkg;

  // Serial divider control states.
  typedef enum logic [1:0] {
    D_IDLE,
    D_RUN,
    D_DONE
  } div_state_e;

  // Reed pulse generator states.
  typedef enum logic {
    STOP,
    RUN
  } pulse_state_e;

  // cm * 36 / (km/h) gives milliseconds per revolution.
  localparam int unsigned KMH_CM_FACTOR = 36;

  localparam int unsigned REV_WIDTH = 16;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, start/busy/done handshake.
module serial_divider
  import bike_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 26
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [DIV_WIDTH-1:0] i_dividend,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [DIV_WIDTH-1:0] o_quotient
);

  localparam int unsigned CntW = $clog2(DIV_WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DIV_WIDTH - 1);

  div_state_e           r_state;
  div_state_e           w_state_next;
  logic [DIV_WIDTH-1:0] r_quo;
  logic [DIV_WIDTH-1:0] r_rem;
  logic [DIV_WIDTH-1:0] r_dvs;
  logic [CntW-1:0]      r_cnt;

  logic [DIV_WIDTH:0]   w_shift;
  logic [DIV_WIDTH:0]   w_diff;
  logic                 w_ge;

  // Partial remainder shifted left with the next dividend bit, then trial subtract.
  assign w_shift = {r_rem, r_quo[DIV_WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[DIV_WIDTH];

  assign o_busy     = (r_state != D_IDLE);
  assign o_done     = (r_state == D_DONE);
  assign o_quotient = r_quo;

  // Next-state decode for the divider control.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      D_IDLE: if (i_start) w_state_next = D_RUN;
      D_RUN:  if (r_cnt == LastBit) w_state_next = D_DONE;
      D_DONE: w_state_next = D_IDLE;
      default: w_state_next = D_IDLE;
    endcase
  end

  // State register and shift/subtract datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= D_IDLE;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == D_IDLE && i_start) begin
        r_quo <= i_dividend;
        r_rem <= '0;
        r_dvs <= i_divisor;
        r_cnt <= '0;
      end else if (r_state == D_RUN) begin
        r_quo <= {r_quo[DIV_WIDTH-2:0], w_ge};
        r_rem <= w_ge ? w_diff[DIV_WIDTH-1:0] : w_shift[DIV_WIDTH-1:0];
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/wheel_emulator.sv
// Reed-sensor emulator: converts speed and circumference into a periodic reed pulse train.
module wheel_emulator
  import bike_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 1000,
  parameter int unsigned DIV_WIDTH = 26,
  parameter int unsigned PULSE_LEN = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [6:0]           speed_set,
  input  logic [7:0]           circ,
  output logic                 reed,
  output logic                 busy,
  output logic [DIV_WIDTH-1:0] period,
  output logic [REV_WIDTH-1:0] rev_count
);

  localparam int unsigned NumScale = KMH_CM_FACTOR * (CLK_HZ / 1000);
  localparam logic [DIV_WIDTH-1:0] MinPeriod = DIV_WIDTH'(2 * PULSE_LEN);
  localparam logic [DIV_WIDTH-1:0] PulseLen  = DIV_WIDTH'(PULSE_LEN);

  logic                 w_busy;
  logic                 w_done;
  logic                 w_start;
  logic [DIV_WIDTH-1:0] w_quotient;
  logic [DIV_WIDTH-1:0] w_dividend;
  logic [DIV_WIDTH-1:0] w_divisor;
  logic [DIV_WIDTH-1:0] w_p_commit;

  logic                 r_zero;
  logic                 r_pend_valid;
  logic [DIV_WIDTH-1:0] r_pend_p;
  pulse_state_e         r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_period;
  logic [REV_WIDTH-1:0] r_rev;
  logic                 r_reed;

  pulse_state_e         w_state_next;
  logic [DIV_WIDTH-1:0] w_cnt_next;
  logic [DIV_WIDTH-1:0] w_period_next;
  logic [REV_WIDTH-1:0] w_rev_next;
  logic                 w_consume;
  logic                 w_pend_valid_next;
  logic [DIV_WIDTH-1:0] w_pend_p_next;

  assign w_start    = load & ~w_busy;
  assign w_dividend = DIV_WIDTH'(circ) * DIV_WIDTH'(NumScale);
  assign w_divisor  = DIV_WIDTH'(speed_set);

  serial_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_div (
    .clock      (clock),
    .reset      (reset),
    .i_start    (w_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_quotient (w_quotient)
  );

  // Zero operands bypass the quotient (divide by zero would yield all ones); tiny periods clamp.
  always_comb begin
    w_p_commit = w_quotient;
    if (r_zero) begin
      w_p_commit = '0;
    end else if (w_quotient != '0 && w_quotient < MinPeriod) begin
      w_p_commit = MinPeriod;
    end
  end

  // Pulse FSM next state, counters and pending-period bookkeeping.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_period_next = r_period;
    w_rev_next    = r_rev;
    w_consume     = 1'b0;
    unique case (r_state)
      STOP: begin
        w_period_next = '0;
        w_cnt_next    = '0;
        if (r_pend_valid) begin
          w_consume = 1'b1;
          if (r_pend_p != '0) begin
            w_state_next  = RUN;
            w_period_next = r_pend_p;
          end
        end
      end
      RUN: begin
        if (enable) begin
          if (r_cnt == r_period - DIV_WIDTH'(1)) begin
            w_cnt_next = '0;
            w_rev_next = r_rev + REV_WIDTH'(1);
            // New periods only take effect on a revolution boundary.
            if (r_pend_valid) begin
              w_consume     = 1'b1;
              w_period_next = r_pend_p;
              if (r_pend_p == '0) w_state_next = STOP;
            end
          end else begin
            w_cnt_next = r_cnt + DIV_WIDTH'(1);
          end
        end
      end
      default: w_state_next = STOP;
    endcase

    // A fresh commit wins over consumption of the older value.
    w_pend_valid_next = r_pend_valid & ~w_consume;
    w_pend_p_next     = r_pend_p;
    if (w_done) begin
      w_pend_valid_next = 1'b1;
      w_pend_p_next     = w_p_commit;
    end
  end

  // Registers for operand flag, pending period, pulse FSM and reed output.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_zero       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_p     <= '0;
      r_state      <= STOP;
      r_cnt        <= '0;
      r_period     <= '0;
      r_rev        <= '0;
      r_reed       <= 1'b0;
    end else begin
      if (w_start) r_zero <= (speed_set == 7'd0) || (circ == 8'd0);
      r_pend_valid <= w_pend_valid_next;
      r_pend_p     <= w_pend_p_next;
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_period     <= w_period_next;
      r_rev        <= w_rev_next;
      r_reed       <= (r_state == RUN) && enable && (r_cnt < PulseLen);
    end
  end

  assign reed      = r_reed;
  assign busy      = w_busy;
  assign period    = r_period;
  assign rev_count = r_rev;

endmodule

// File: tb/tb_wheel_emulator.sv
// Directed self-checking bench for wheel_emulator (CLK_HZ=1000, DIV_WIDTH=26, PULSE_LEN=5).
module tb_wheel_emulator;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        load;
  logic [6:0]  speed_set;
  logic [7:0]  circ;
  logic        reed;
  logic        busy;
  logic [25:0] period;
  logic [15:0] rev_count;

  int checks;
  int errors;

  wheel_emulator #(
    .CLK_HZ    (1000),
    .DIV_WIDTH (26),
    .PULSE_LEN (5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .speed_set (speed_set),
    .circ      (circ),
    .reed      (reed),
    .busy      (busy),
    .period    (period),
    .rev_count (rev_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input int c, input int s);
    circ      = 8'(c);
    speed_set = 7'(s);
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  // Ticks until the next sampled 0->1 transition of reed, bounded.
  task automatic measure_rise(output int n);
    logic prev;
    n = 0;
    do begin
      prev = reed;
      tick();
      n++;
    end while (!(prev == 1'b0 && reed == 1'b1) && n < 1000);
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (reed !== 1'b0) begin errors++; $display("FAIL reset_reed got %0b want 0", reed); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (period !== 26'd0) begin errors++; $display("FAIL reset_period got %0d want 0", period); end
    checks++; if (rev_count !== 16'd0) begin errors++; $display("FAIL reset_rev got %0d want 0", rev_count); end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (reed !== 1'b0 || period !== 26'd0 || rev_count !== 16'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_1000 got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_load_200();
    int nb, lat, hi, n;
    do_load(200, 36);
    nb = 0;
    lat = 0;
    while (reed !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) nb++;
      tick();
      lat++;
    end
    checks++; if (nb != 27) begin errors++; $display("FAIL busy_len got %0d want 27", nb); end
    checks++; if (lat != 29) begin errors++; $display("FAIL first_reed_latency got %0d want 29", lat); end
    checks++; if (period !== 26'd200) begin errors++; $display("FAIL period_200 got %0d want 200", period); end
    hi = 0;
    while (reed === 1'b1 && hi < 100) begin
      tick();
      hi++;
    end
    checks++; if (hi != 5) begin errors++; $display("FAIL pulse_high got %0d want 5", hi); end
    measure_rise(n);
    checks++; if (hi + n != 200) begin errors++; $display("FAIL rise_interval got %0d want 200", hi + n); end
    repeat (1800) tick();
    checks++; if (rev_count !== 16'd10) begin errors++; $display("FAIL rev_10 got %0d want 10", rev_count); end
  endtask

  // Entered on a reed rising sample (cnt = 1).
  task automatic test_speed_change();
    int n;
    repeat (49) tick();
    do_load(200, 72);
    measure_rise(n);
    checks++; if (50 + n != 200) begin errors++; $display("FAIL rev_kept_200 got %0d want 200", 50 + n); end
    measure_rise(n);
    checks++; if (n != 100) begin errors++; $display("FAIL rev_next_100 got %0d want 100", n); end
    checks++; if (period !== 26'd100) begin errors++; $display("FAIL period_100 got %0d want 100", period); end
  endtask

  // Entered on a reed rising sample at period 100 with rev_count 12.
  task automatic test_stop();
    int highs;
    do_load(200, 0);
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      if (reed === 1'b1) highs++;
      tick();
    end
    checks++; if (highs != 4) begin errors++; $display("FAIL stop_reed_highs got %0d want 4", highs); end
    checks++; if (period !== 26'd0) begin errors++; $display("FAIL stop_period got %0d want 0", period); end
    checks++; if (rev_count !== 16'd13) begin errors++; $display("FAIL stop_rev got %0d want 13", rev_count); end
  endtask

  task automatic test_clamp();
    int lat, n;
    do_load(1, 99);
    repeat (40) tick();
    checks++; if (period !== 26'd0) begin errors++; $display("FAIL trunc_zero_period got %0d want 0", period); end
    checks++; if (reed !== 1'b0) begin errors++; $display("FAIL trunc_zero_reed got %0b want 0", reed); end
    do_load(10, 99);
    lat = 0;
    while (reed !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    checks++; if (lat != 29) begin errors++; $display("FAIL clamp_latency got %0d want 29", lat); end
    checks++; if (period !== 26'd10) begin errors++; $display("FAIL clamp_period got %0d want 10", period); end
    measure_rise(n);
    checks++; if (n != 10) begin errors++; $display("FAIL clamp_interval got %0d want 10", n); end
  endtask

  task automatic test_ignore_load();
    do_load(200, 36);
    repeat (4) tick();
    do_load(200, 72);
    repeat (60) tick();
    checks++; if (period !== 26'd200) begin errors++; $display("FAIL ignored_load_period got %0d want 200", period); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_load_busy got %0b want 0", busy); end
  endtask

  task automatic test_enable_stretch();
    int n, bad;
    measure_rise(n);
    repeat (20) tick();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (reed !== 1'b0) bad++;
    end
    enable = 1'b1;
    checks++; if (bad != 0) begin errors++; $display("FAIL disabled_reed got %0d high samples want 0", bad); end
    measure_rise(n);
    checks++; if (50 + n != 230) begin errors++; $display("FAIL stretch got %0d want 230", 50 + n); end
  endtask

  task automatic test_reset_mid_divide();
    do_load(200, 72);
    repeat (9) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (60) tick();
    checks++; if (period !== 26'd0) begin errors++; $display("FAIL midreset_period got %0d want 0", period); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
    checks++; if (rev_count !== 16'd0) begin errors++; $display("FAIL midreset_rev got %0d want 0", rev_count); end
    checks++; if (reed !== 1'b0) begin errors++; $display("FAIL midreset_reed got %0b want 0", reed); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    enable    = 1'b1;
    load      = 1'b0;
    speed_set = 7'd0;
    circ      = 8'd0;
    test_reset();
    test_load_200();
    test_speed_change();
    test_stop();
    test_clamp();
    test_ignore_load();
    test_enable_stretch();
    test_reset_mid_divide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wheel_emulator.md
# wheel_emulator

Synthesizable reed-sensor transmitter for the bicycle computer. It converts a programmed speed (km/h) and wheel circumference (cm) into a periodic `reed` pulse train, driving the same `reed`/`circ` inputs the computer consumes. It is used in closed-loop benches and in the on-board self-test path, feeding the distance and speed paths with known revolution timing. Period computation uses an internal serial divider, so no combinational divide appears in the datapath.

## Interface
- `CLK_HZ`, 1000: clock frequency in Hz; must be a multiple of 1000.
- `DIV_WIDTH`, 26: width of the period numerator, the divider and the period counter.
- `PULSE_LEN`, 5: cycles `reed` stays high per revolution.
- `clock`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run pulse train; low forces `reed` low and holds the counter.
- `load`  in  1  one-cycle strobe; samples `speed_set` and `circ`.
- `speed_set`  in  7  target speed, integer km/h, 0..99; 0 means stopped.
- `circ`  in  8  wheel circumference, cm.
- `reed`  out  1  emulated reed contact, active high.
- `busy`  out  1  divider running; `load` is ignored while high.
- `period`  out  DIV_WIDTH  active revolution period, in cycles; 0 means stopped.
- `rev_count`  out  16  revolutions emitted since reset; wraps at 65535 to 0.

## Operation
- Numerator N = `circ` × 36 × (CLK_HZ/1000), computed at load. Pending period P = N / `speed_set`, truncated.
- If `speed_set` is 0 or `circ` is 0, P = 0.
- If P is nonzero and P < 2×PULSE_LEN, P is clamped to 2×PULSE_LEN.
- Divider FSM has three states:
  - D_IDLE: on `load` with `busy` low, latch the operands and go to D_RUN.
  - D_RUN: restoring shift/subtract, one quotient bit per cycle, DIV_WIDTH cycles, then go to D_DONE.
  - D_DONE: commit P to the pending register, set the pending-valid flag, return to D_IDLE.
- Pulse FSM has two states:
  - STOP: `period` = 0 and `reed` = 0. A pending-valid flag with nonzero P loads `period`, clears `cnt` to 0 and moves to RUN. A pending P of 0 stays in STOP and clears the flag.
  - RUN: `cnt` increments each enabled cycle. At `cnt` = `period`−1, `cnt` wraps to 0 and `rev_count` increments.
  - RUN, pending update: at a wrap with the pending-valid flag set, `period` takes P. If P = 0, go to STOP. The current revolution always completes first; there is no mid-revolution change.
- `reed` = RUN && `enable` && `cnt` < PULSE_LEN. The output is registered.
- `enable` low: `cnt` holds, `reed` = 0, `rev_count` holds. The divider still accepts `load`.
- Only the last committed pending P is kept; a newer commit overwrites an unapplied one.

## Timing
- Reset values: `reed` 0, `busy` 0, `period` 0, `rev_count` 0, `cnt` 0. Divider returns to D_IDLE, the pending-valid flag clears, and the pulse FSM returns to STOP.
- Reset mid-division aborts the division; no commit occurs.
- Load handshake, with `load` sampled at edge t:
  - `busy` is high during cycles t+1 through t+DIV_WIDTH+1.
  - P is committed at edge t+DIV_WIDTH+1.
  - `load` while `busy` is high is dropped silently.
- From STOP, `period` updates one edge after commit. `reed` first rises on the next edge, giving a latency from `load` to first `reed` high of DIV_WIDTH+3 edges.
- In RUN, `reed` has a rising edge every `period` cycles. The high time is exactly PULSE_LEN cycles.
- Simultaneous commit and wrap in the same cycle: the flag is set at the edge and applies at the next wrap.

## Structure
- Shared package `bike_pkg` holds:
  - the divider state encoding (D_IDLE/D_RUN/D_DONE),
  - the pulse state encoding (STOP/RUN),
  - the constant 36 (cm·km/h conversion factor),
  - the `rev_count` width.
- One sub-module, `serial_divider`: unsigned restoring divider with start/busy/done handshake, parameterized by DIV_WIDTH.
- `wheel_emulator` holds the operand latch, pending register, pulse FSM and counters.

## Test plan
All scenarios use CLK_HZ=1000, DIV_WIDTH=26, PULSE_LEN=5.
- Reset release, no load -> `reed` 0, `period` 0 and `rev_count` 0 for 1000 cycles.
- `load` with `circ`=200, `speed_set`=36 -> `busy` high for 27 cycles; `period`=200; `reed` high 5 cycles every 200 cycles; `rev_count`=10 after 10 periods.
- While running at 200, `load` with `speed_set`=72 at `cnt`=50 -> the current revolution stays at 200 cycles; the next revolution is 100 cycles.
- `load` with `speed_set`=0 while running -> the current revolution completes, then `reed` stays 0, `period` becomes 0 and `rev_count` freezes.
- `circ`=1, `speed_set`=99 -> P=0 truncates to 0, so the block stays stopped. `circ`=10, `speed_set`=99 -> 360/99=3, clamped to `period`=10.
- Second `load` issued 5 cycles into a divide is ignored (old operands result). `enable` low for 30 cycles mid-revolution stretches that revolution by exactly 30 cycles. `reset` asserted mid-divide leaves `period` at 0 afterward.
